// File: rtl/execute_stage_mc.sv
// Multi-cycle execute stage with built-in EX/MEM register.
// Single-cycle ALU ops retire in one edge; mul runs an iterative shift-add over N = DATA_W/BPC edges.
module execute_stage_mc #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned BPC    = 1,
    parameter int unsigned REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    input  logic [DATA_W-1:0] immediate,
    input  logic              alu_src,
    input  logic              reg_dst,
    input  logic [1:0]        alu_op,
    input  logic              mem_write_in,
    input  logic              mem_read_in,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [REG_AW-1:0] rt,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic              flush,
    output logic              ex_busy,
    output logic              ex_mem_valid,
    output logic [DATA_W-1:0] ex_mem_alu_result,
    output logic [DATA_W-1:0] ex_mem_write_data,
    output logic [REG_AW-1:0] ex_mem_write_reg,
    output logic              ex_mem_mem_write,
    output logic              ex_mem_mem_read,
    output logic              ex_mem_mem_to_reg,
    output logic              ex_mem_reg_write
);

    localparam int unsigned N     = DATA_W / BPC;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_SLT  = 6'h2a;
    localparam logic [5:0] F_SLTU = 6'h2b;
    localparam logic [5:0] F_MUL  = 6'h18;

    typedef enum logic {IDLE, MUL} state_t;

    state_t              state, state_n;
    logic [CNT_W-1:0]    count, count_n;
    logic [DATA_W-1:0]   mul_a, mul_a_n;
    logic [DATA_W-1:0]   mul_b, mul_b_n;
    logic [DATA_W-1:0]   acc, acc_n;
    logic [REG_AW-1:0]   mul_wreg, mul_wreg_n;
    logic [3:0]          mul_ctrl, mul_ctrl_n;

    logic                valid_n;
    logic [DATA_W-1:0]   result_n;
    logic [DATA_W-1:0]   wdata_n;
    logic [REG_AW-1:0]   wreg_n;
    logic [3:0]          ctrl_n;

    logic [DATA_W-1:0]   op_a, fwd_b_val, op_b, alu_res, pp_sum;
    logic [REG_AW-1:0]   write_reg;
    logic [3:0]          ctrl_in;
    logic [5:0]          funct;
    logic                is_mul;

    assign funct     = immediate[5:0];
    assign write_reg = reg_dst ? rd : rt;
    assign ctrl_in   = {mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in};
    assign is_mul    = (alu_op == 2'b10) && (funct == F_MUL);
    assign op_b      = alu_src ? immediate : fwd_b_val;

    // Forwarding muxes; code 11 falls back to the register value.
    always_comb begin
        case (fwd_a)
            2'b01:   op_a = wb_data;
            2'b10:   op_a = mem_data;
            default: op_a = read_data1;
        endcase
        case (fwd_b)
            2'b01:   fwd_b_val = wb_data;
            2'b10:   fwd_b_val = mem_data;
            default: fwd_b_val = read_data2;
        endcase
    end

    // Single-cycle ALU; mul is handled by the iterative path.
    always_comb begin
        alu_res = '0;
        case (alu_op)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            2'b11: alu_res = op_a & op_b;
            default: begin
                case (funct)
                    F_ADD:   alu_res = op_a + op_b;
                    F_SUB:   alu_res = op_a - op_b;
                    F_AND:   alu_res = op_a & op_b;
                    F_OR:    alu_res = op_a | op_b;
                    F_SLT:   alu_res = DATA_W'($signed(op_a) < $signed(op_b));
                    F_SLTU:  alu_res = DATA_W'(op_a < op_b);
                    default: alu_res = '0;
                endcase
            end
        endcase
    end

    // BPC partial products folded into the accumulator per cycle.
    always_comb begin
        pp_sum = acc;
        for (int j = 0; j < int'(BPC); j++) begin
            if (mul_b[j]) pp_sum = pp_sum + (mul_a << j);
        end
    end

    // Next-state, EX/MEM next values and the stall request.
    always_comb begin
        state_n    = state;
        count_n    = count;
        mul_a_n    = mul_a;
        mul_b_n    = mul_b;
        acc_n      = acc;
        mul_wreg_n = mul_wreg;
        mul_ctrl_n = mul_ctrl;
        valid_n    = 1'b0;
        ctrl_n     = 4'b0;
        result_n   = ex_mem_alu_result;
        wdata_n    = ex_mem_write_data;
        wreg_n     = ex_mem_write_reg;
        ex_busy    = 1'b0;

        if (flush) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && is_mul) begin
                        ex_busy    = 1'b1;
                        state_n    = MUL;
                        count_n    = '0;
                        acc_n      = '0;
                        mul_a_n    = op_a;
                        mul_b_n    = fwd_b_val;
                        mul_wreg_n = write_reg;
                        mul_ctrl_n = ctrl_in;
                    end else begin
                        result_n = alu_res;
                        wdata_n  = fwd_b_val;
                        wreg_n   = write_reg;
                        valid_n  = in_valid;
                        ctrl_n   = in_valid ? ctrl_in : 4'b0;
                    end
                end
                MUL: begin
                    ex_busy = (count != LAST);
                    acc_n   = pp_sum;
                    mul_a_n = mul_a << BPC;
                    mul_b_n = mul_b >> BPC;
                    count_n = count + CNT_W'(1);
                    if (count == LAST) begin
                        state_n  = IDLE;
                        count_n  = '0;
                        result_n = pp_sum;
                        wreg_n   = mul_wreg;
                        ctrl_n   = mul_ctrl;
                        valid_n  = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            mul_a             <= '0;
            mul_b             <= '0;
            acc               <= '0;
            mul_wreg          <= '0;
            mul_ctrl          <= '0;
            ex_mem_valid      <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_write_data <= '0;
            ex_mem_write_reg  <= '0;
            ex_mem_mem_write  <= 1'b0;
            ex_mem_mem_read   <= 1'b0;
            ex_mem_mem_to_reg <= 1'b0;
            ex_mem_reg_write  <= 1'b0;
        end else begin
            state             <= state_n;
            count             <= count_n;
            mul_a             <= mul_a_n;
            mul_b             <= mul_b_n;
            acc               <= acc_n;
            mul_wreg          <= mul_wreg_n;
            mul_ctrl          <= mul_ctrl_n;
            ex_mem_valid      <= valid_n;
            ex_mem_alu_result <= result_n;
            ex_mem_write_data <= wdata_n;
            ex_mem_write_reg  <= wreg_n;
            ex_mem_mem_write  <= ctrl_n[3];
            ex_mem_mem_read   <= ctrl_n[2];
            ex_mem_mem_to_reg <= ctrl_n[1];
            ex_mem_reg_write  <= ctrl_n[0];
        end
    end

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc: ALU ops, forwarding, multiply timing, flush and reset.
module tb_execute_stage_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] read_data1, read_data2, immediate;
    logic        alu_src, reg_dst;
    logic [1:0]  alu_op;
    logic        mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in;
    logic [4:0]  rt, rd;
    logic [31:0] mem_data, wb_data;
    logic [1:0]  fwd_a, fwd_b;
    logic        flush;
    logic        ex_busy, ex_mem_valid;
    logic [31:0] ex_mem_alu_result, ex_mem_write_data;
    logic [4:0]  ex_mem_write_reg;
    logic        ex_mem_mem_write, ex_mem_mem_read, ex_mem_mem_to_reg, ex_mem_reg_write;

    int compared   = 0;
    int mismatched = 0;
    int busy_cnt;

    execute_stage_mc #(.DATA_W(32), .BPC(1), .REG_AW(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .read_data1(read_data1), .read_data2(read_data2), .immediate(immediate),
        .alu_src(alu_src), .reg_dst(reg_dst), .alu_op(alu_op),
        .mem_write_in(mem_write_in), .mem_read_in(mem_read_in),
        .mem_to_reg_in(mem_to_reg_in), .reg_write_in(reg_write_in),
        .rt(rt), .rd(rd), .mem_data(mem_data), .wb_data(wb_data),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .flush(flush),
        .ex_busy(ex_busy), .ex_mem_valid(ex_mem_valid),
        .ex_mem_alu_result(ex_mem_alu_result), .ex_mem_write_data(ex_mem_write_data),
        .ex_mem_write_reg(ex_mem_write_reg), .ex_mem_mem_write(ex_mem_mem_write),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_to_reg(ex_mem_mem_to_reg),
        .ex_mem_reg_write(ex_mem_reg_write)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // R-type op with register operands, destination rd, reg_write set.
    task automatic set_r(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] dst);
        in_valid = 1'b1; alu_op = 2'b10; immediate = {26'b0, fn}; alu_src = 1'b0;
        read_data1 = a; read_data2 = b; fwd_a = 2'b00; fwd_b = 2'b00;
        reg_dst = 1'b1; rd = dst; rt = 5'd0;
        mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0; reg_write_in = 1'b1;
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_valid"}, 32'(ex_mem_valid), 32'd0);
        chk({tag, "_result"}, ex_mem_alu_result, 32'd0);
        chk({tag, "_wdata"}, ex_mem_write_data, 32'd0);
        chk({tag, "_wreg"}, 32'(ex_mem_write_reg), 32'd0);
        chk({tag, "_ctrl"}, 32'({ex_mem_mem_write, ex_mem_mem_read,
                                  ex_mem_mem_to_reg, ex_mem_reg_write}), 32'd0);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0;
        read_data1 = '0; read_data2 = '0; immediate = '0; alu_src = 1'b0; reg_dst = 1'b0;
        alu_op = 2'b00; mem_write_in = 1'b0; mem_read_in = 1'b0; mem_to_reg_in = 1'b0;
        reg_write_in = 1'b0; rt = '0; rd = '0; mem_data = '0; wb_data = '0;
        fwd_a = '0; fwd_b = '0;
        tick(); tick();
        chk_zero_outputs("reset");
        chk("reset_busy", 32'(ex_busy), 32'd0);
        reset = 1'b0;

        // add 5 + 7
        set_r(6'h20, 32'd5, 32'd7, 5'd3);
        #1 chk("add_busy", 32'(ex_busy), 32'd0);
        tick();
        chk("add_result", ex_mem_alu_result, 32'd12);
        chk("add_valid", 32'(ex_mem_valid), 32'd1);
        chk("add_wreg", 32'(ex_mem_write_reg), 32'd3);
        chk("add_regwrite", 32'(ex_mem_reg_write), 32'd1);
        chk("add_wdata", ex_mem_write_data, 32'd7);
        chk("add_busy_after", 32'(ex_busy), 32'd0);

        // forwarding: mem_data - wb_data, then read_data1 - wb_data with fwd_a=11
        set_r(6'h22, 32'd50, 32'd40, 5'd4);
        fwd_a = 2'b10; mem_data = 32'd100; fwd_b = 2'b01; wb_data = 32'd3;
        tick();
        chk("fwd_sub", ex_mem_alu_result, 32'd97);
        chk("fwd_store_data", ex_mem_write_data, 32'd3);
        fwd_a = 2'b11; read_data1 = 32'd9;
        tick();
        chk("fwd11_sub", ex_mem_alu_result, 32'd6);

        // alu_op 00 with immediate, rt destination
        set_r(6'h0a, 32'd5, 32'd99, 5'd9);
        alu_op = 2'b00; alu_src = 1'b1; reg_dst = 1'b0; rt = 5'd17;
        mem_read_in = 1'b1; mem_to_reg_in = 1'b1;
        tick();
        chk("addi_result", ex_mem_alu_result, 32'd15);
        chk("addi_wreg_rt", 32'(ex_mem_write_reg), 32'd17);
        chk("addi_store_data", ex_mem_write_data, 32'd99);
        chk("addi_ctrl", 32'({ex_mem_mem_write, ex_mem_mem_read,
                              ex_mem_mem_to_reg, ex_mem_reg_write}), 32'b0111);

        set_r(6'h00, 32'h0000_00F0, 32'h0000_003C, 5'd1);
        alu_op = 2'b11;
        tick();
        chk("and_op11", ex_mem_alu_result, 32'h30);
        set_r(6'h00, 32'd3, 32'd5, 5'd1);
        alu_op = 2'b01;
        tick();
        chk("sub_wrap", ex_mem_alu_result, 32'hFFFF_FFFE);

        // slt / sltu / or / unknown funct
        set_r(6'h2a, 32'hFFFF_FFFF, 32'd1, 5'd2);
        tick();
        chk("slt", ex_mem_alu_result, 32'd1);
        set_r(6'h2b, 32'hFFFF_FFFF, 32'd1, 5'd2);
        tick();
        chk("sltu", ex_mem_alu_result, 32'd0);
        set_r(6'h25, 32'hF0, 32'h0F, 5'd2);
        tick();
        chk("or", ex_mem_alu_result, 32'hFF);
        set_r(6'h3f, 32'd123, 32'd45, 5'd2);
        tick();
        chk("funct3f", ex_mem_alu_result, 32'd0);

        // in_valid low: bubble
        set_r(6'h20, 32'd1, 32'd2, 5'd5);
        in_valid = 1'b0;
        tick();
        chk("bubble_valid", 32'(ex_mem_valid), 32'd0);
        chk("bubble_regwrite", 32'(ex_mem_reg_write), 32'd0);

        // multiply 0x10001 * 0x10001, then add 2+3 queued behind it
        busy_cnt = 0;
        set_r(6'h18, 32'h0001_0001, 32'h0001_0001, 5'd7);
        #1 chk("mul_issue_busy", 32'(ex_busy), 32'd1);
        if (ex_busy) busy_cnt++;
        tick();
        chk("mul_issue_bubble", 32'(ex_mem_valid), 32'd0);
        set_r(6'h20, 32'd2, 32'd3, 5'd4);
        for (int k = 1; k <= 32; k++) begin
            #1;
            if (ex_busy) busy_cnt++;
            chk("mul_busy", 32'(ex_busy), (k != 32) ? 32'd1 : 32'd0);
            tick();
            if (k < 32) begin
                chk("mul_bubble", 32'(ex_mem_valid), 32'd0);
            end else begin
                chk("mul_valid", 32'(ex_mem_valid), 32'd1);
                chk("mul_result", ex_mem_alu_result, 32'h0002_0001);
                chk("mul_wreg", 32'(ex_mem_write_reg), 32'd7);
                chk("mul_regwrite", 32'(ex_mem_reg_write), 32'd1);
            end
        end
        chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
        #1 chk("post_mul_busy", 32'(ex_busy), 32'd0);
        tick();
        chk("post_mul_add", ex_mem_alu_result, 32'd5);
        chk("post_mul_add_wreg", 32'(ex_mem_write_reg), 32'd4);
        chk("post_mul_add_valid", 32'(ex_mem_valid), 32'd1);

        // flush at count = 10 aborts the multiply
        set_r(6'h18, 32'd3, 32'd5, 5'd8);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        flush = 1'b1;
        #1 chk("flush_busy", 32'(ex_busy), 32'd0);
        tick();
        flush = 1'b0;
        chk("flush_valid", 32'(ex_mem_valid), 32'd0);
        chk("flush_regwrite", 32'(ex_mem_reg_write), 32'd0);
        #1 chk("flush_busy_after", 32'(ex_busy), 32'd0);
        for (int k = 0; k < 30; k++) begin
            tick();
            chk("flush_no_product", 32'(ex_mem_valid), 32'd0);
        end
        set_r(6'h20, 32'd1, 32'd1, 5'd6);
        tick();
        chk("flush_idle_add", ex_mem_alu_result, 32'd2);
        chk("flush_idle_valid", 32'(ex_mem_valid), 32'd1);

        // reset with flush during a multiply
        set_r(6'h18, 32'd3, 32'd5, 5'd8);
        tick();
        repeat (3) tick();
        reset = 1'b1; flush = 1'b1;
        tick();
        chk_zero_outputs("mul_reset");
        chk("mul_reset_busy", 32'(ex_busy), 32'd0);
        reset = 1'b0; flush = 1'b0;
        set_r(6'h20, 32'd1, 32'd1, 5'd6);
        #1 chk("after_reset_busy", 32'(ex_busy), 32'd0);
        tick();
        chk("after_reset_add", ex_mem_alu_result, 32'd2);
        chk("after_reset_valid", 32'(ex_mem_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
